// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared fetch-unit definitions: redirect sources, controller states, reset PC
// and fetch-group size, and the redirect request payload.
package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam int unsigned FETCH_BYTES = 8;
  localparam int unsigned PC_W        = 32;

  // Encoding matches the redirSrc output: 0 none, 1 if3, 2 bru, 3 exc.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF3  = 2'd1,
    SRC_BRU  = 2'd2,
    SRC_EXC  = 2'd3
  } redirect_src_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    redirect_src_t     src;
    logic [PC_W-1:0]   pc;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_prio_sel.sv
// Priority mux over the redirect sources: exc > bru > if3.
// IF3 redirects are ignored while waiting on an uncancellable miss.
// Ports: excRedirect/excPC, bruRedirect/bruPC, if3Redirect/if3PC requests,
//        state (controller state), sel (chosen redirect, valid=0 if none).
module redirect_prio_sel
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic         excRedirect,
  input  logic [31:0]  excPC,
  input  logic         bruRedirect,
  input  logic [31:0]  bruPC,
  input  logic         if3Redirect,
  input  logic [31:0]  if3PC,
  input  fetch_state_t state,
  output redirect_t    sel
);

  always_comb begin
    sel = '0;
    if (excRedirect) begin
      sel.valid = 1'b1;
      sel.src   = SRC_EXC;
      sel.pc    = excPC;
    end else if (bruRedirect) begin
      sel.valid = 1'b1;
      sel.src   = SRC_BRU;
      sel.pc    = bruPC;
    end else if (if3Redirect && (state != ST_WAIT)) begin
      sel.valid = 1'b1;
      sel.src   = SRC_IF3;
      sel.pc    = if3PC;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: picks the next IF1 request from redirects or sequential
// fetch, parks a redirect behind an in-flight ICache miss and drops the stale
// response when it returns.
// Ports: clk, rst (sync, active-high); excRedirect/excPC, bruRedirect/bruPC,
//        if3Redirect/if3PC redirect sources; pauseReq holds fetch;
//        icacheReady/icacheRespValid from the ICache; fetchReq/fetchPC to IF1;
//        flushFrontend, dropResp, redirSrc status (combinational).
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC    = fetch_redirect_ctrl_pkg::RESET_PC,
  parameter int unsigned FETCH_BYTES = fetch_redirect_ctrl_pkg::FETCH_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excRedirect,
  input  logic [31:0] excPC,
  input  logic        bruRedirect,
  input  logic [31:0] bruPC,
  input  logic        if3Redirect,
  input  logic [31:0] if3PC,
  input  logic        pauseReq,
  input  logic        icacheReady,
  input  logic        icacheRespValid,
  output logic        fetchReq,
  output logic [31:0] fetchPC,
  output logic        flushFrontend,
  output logic        dropResp,
  output logic [1:0]  redirSrc
);

  import fetch_redirect_ctrl_pkg::*;

  fetch_state_t  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   pend_pc_q;
  redirect_src_t pend_src_q;

  redirect_t     sel;
  logic          repl;
  logic [31:0]   pc_step;

  redirect_prio_sel u_sel (
    .excRedirect (excRedirect),
    .excPC       (excPC),
    .bruRedirect (bruRedirect),
    .bruPC       (bruPC),
    .if3Redirect (if3Redirect),
    .if3PC       (if3PC),
    .state       (state_q),
    .sel         (sel)
  );

  // A group starting at pc[2]=1 holds one instruction; step realigns to 8B.
  assign pc_step = pc_q[2] ? 32'd4 : 32'(FETCH_BYTES);
  assign fetchPC = pc_q;

  // Request/flush/drop decode; everything is quiet while rst is held.
  always_comb begin
    fetchReq      = 1'b0;
    flushFrontend = 1'b0;
    dropResp      = 1'b0;
    redirSrc      = 2'd0;
    repl          = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          fetchReq = !pauseReq && !sel.valid;
          if (sel.valid) begin
            flushFrontend = 1'b1;
            redirSrc      = 2'(sel.src);
            dropResp      = icacheRespValid;
          end
        end
        ST_WAIT: begin
          dropResp = icacheRespValid;
          // exc overrides anything; bru overrides everything except exc.
          repl = sel.valid && ((sel.src == SRC_EXC) || (pend_src_q != SRC_EXC));
          if (repl) begin
            flushFrontend = 1'b1;
            redirSrc      = 2'(sel.src);
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      pend_src_q <= SRC_NONE;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        ST_RUN: begin
          if (sel.valid) begin
            if (icacheReady) begin
              pc_q <= sel.pc;
            end else begin
              pend_pc_q  <= sel.pc;
              pend_src_q <= sel.src;
              state_q    <= ST_WAIT;
            end
          end else if (fetchReq && icacheReady) begin
            pc_q <= pc_q + pc_step;
          end
        end
        ST_WAIT: begin
          if (repl) begin
            pend_pc_q  <= sel.pc;
            pend_src_q <= sel.src;
          end
          if (icacheReady) begin
            pc_q       <= repl ? sel.pc : pend_pc_q;
            pend_src_q <= SRC_NONE;
            state_q    <= ST_RUN;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Table-driven bench: each row is one cycle of inputs plus the outputs that
// must be seen in that cycle; expectations travel through a scoreboard queue.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        excRedirect, bruRedirect, if3Redirect;
  logic [31:0] excPC, bruPC, if3PC;
  logic        pauseReq, icacheReady, icacheRespValid;
  logic        fetchReq, flushFrontend, dropResp;
  logic [31:0] fetchPC;
  logic [1:0]  redirSrc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .excRedirect     (excRedirect),
    .excPC           (excPC),
    .bruRedirect     (bruRedirect),
    .bruPC           (bruPC),
    .if3Redirect     (if3Redirect),
    .if3PC           (if3PC),
    .pauseReq        (pauseReq),
    .icacheReady     (icacheReady),
    .icacheRespValid (icacheRespValid),
    .fetchReq        (fetchReq),
    .fetchPC         (fetchPC),
    .flushFrontend   (flushFrontend),
    .dropResp        (dropResp),
    .redirSrc        (redirSrc)
  );

  typedef struct {
    logic        rst;
    logic        exc;
    logic [31:0] epc;
    logic        bru;
    logic [31:0] bpc;
    logic        if3;
    logic [31:0] ipc;
    logic        pause;
    logic        rdy;
    logic        resp;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_drop;
    logic [1:0]  e_src;
  } vec_t;

  typedef struct {
    int          idx;
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        drop;
    logic [1:0]  src;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic r, input logic e, input logic [31:0] ep,
                     input logic b, input logic [31:0] bp,
                     input logic i, input logic [31:0] ip,
                     input logic p, input logic rd, input logic rs,
                     input logic xq, input logic [31:0] xpc,
                     input logic xf, input logic xd, input logic [1:0] xs);
    vec_t v;
    v.rst = r; v.exc = e; v.epc = ep; v.bru = b; v.bpc = bp;
    v.if3 = i; v.ipc = ip; v.pause = p; v.rdy = rd; v.resp = rs;
    v.e_req = xq; v.e_pc = xpc; v.e_flush = xf; v.e_drop = xd; v.e_src = xs;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %h want %h", idx, name, act, exp);
    end
  endtask

  // Outputs are sampled mid-cycle, well after inputs settle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("fetchReq",      x.idx, 32'(fetchReq),      32'(x.req));
      chk("fetchPC",       x.idx, fetchPC,            x.pc);
      chk("flushFrontend", x.idx, 32'(flushFrontend), 32'(x.flush));
      chk("dropResp",      x.idx, 32'(dropResp),      32'(x.drop));
      chk("redirSrc",      x.idx, 32'(redirSrc),      32'(x.src));
    end
  end

  initial begin
    rst = 1'b1; excRedirect = 1'b0; bruRedirect = 1'b0; if3Redirect = 1'b0;
    excPC = '0; bruPC = '0; if3PC = '0;
    pauseReq = 1'b0; icacheReady = 1'b1; icacheRespValid = 1'b0;

    // Reset, boot, sequential fetch
    for (int k = 0; k < 3; k++)
      add(1,0,0,0,0,0,0,0,1,0, 0,32'hBFC0_0000,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 0,32'hBFC0_0000,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'hBFC0_0000,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'hBFC0_0008,0,0,0);
    // bru beats if3, single-inst group then realign
    add(0,0,0,1,32'h8000_1004,1,32'hBFC0_0100,0,1,0, 0,32'hBFC0_0010,1,0,2);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'h8000_1004,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'h8000_1008,0,0,0);
    // if3 behind a miss, exc overwrites, stale response dropped
    add(0,0,0,0,0,1,32'h0040_0020,0,0,0, 0,32'h8000_1010,1,0,1);
    add(0,1,32'hBFC0_0380,0,0,0,0,0,0,0, 0,32'h8000_1010,1,0,3);
    add(0,0,0,0,0,0,0,0,0,1, 0,32'h8000_1010,0,1,0);
    add(0,0,0,0,0,0,0,0,1,0, 0,32'h8000_1010,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'hBFC0_0380,0,0,0);
    // pending bru, if3 in WAIT ignored
    add(0,0,0,1,32'h0040_0004,0,0,0,0,0, 0,32'hBFC0_0388,1,0,2);
    add(0,0,0,0,0,1,32'h1234_5678,0,0,0, 0,32'hBFC0_0388,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 0,32'hBFC0_0388,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'h0040_0004,0,0,0);
    // pause 4 cycles, exc during pause still taken, resp+flush drops
    add(0,0,0,0,0,0,0,1,1,0, 0,32'h0040_0008,0,0,0);
    add(0,0,0,0,0,0,0,1,1,0, 0,32'h0040_0008,0,0,0);
    add(0,1,32'h0000_0100,0,0,0,0,1,1,1, 0,32'h0040_0008,1,1,3);
    add(0,0,0,0,0,0,0,1,1,0, 0,32'h0000_0100,0,0,0);
    add(0,0,0,0,0,0,0,0,1,1, 1,32'h0000_0100,0,0,0);
    // reset while in WAIT
    add(0,0,0,1,32'h0000_2000,0,0,0,0,0, 0,32'h0000_0108,1,0,2);
    add(1,0,0,0,0,0,0,0,0,1, 0,32'h0000_0108,0,0,0);
    add(0,0,0,0,0,0,0,0,0,1, 0,32'hBFC0_0000,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'hBFC0_0000,0,0,0);

    // Hand-written corners: exc over bru, PC wrap at 2^32
    add(0,1,32'hFFFF_FFF8,1,32'h1111_1110,0,0,0,1,0, 0,32'hBFC0_0008,1,0,3);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'hFFFF_FFF8,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'h0000_0000,0,0,0);
    // Pending exc is not displaced by a later bru
    add(0,1,32'h0000_A000,0,0,0,0,0,0,0, 0,32'h0000_0008,1,0,3);
    add(0,0,0,1,32'h0000_B000,0,0,0,0,0, 0,32'h0000_0008,0,0,0);
    add(0,0,0,1,32'h0000_B000,0,0,0,1,0, 0,32'h0000_0008,0,0,0);
    add(0,0,0,0,0,0,0,0,1,0, 1,32'h0000_A000,0,0,0);

    @(posedge clk);
    foreach (vecs[n]) begin
      exp_t x;
      @(posedge clk);
      #1;
      rst = vecs[n].rst;
      excRedirect = vecs[n].exc;  excPC = vecs[n].epc;
      bruRedirect = vecs[n].bru;  bruPC = vecs[n].bpc;
      if3Redirect = vecs[n].if3;  if3PC = vecs[n].ipc;
      pauseReq = vecs[n].pause;
      icacheReady = vecs[n].rdy;
      icacheRespValid = vecs[n].resp;
      x.idx = n; x.req = vecs[n].e_req; x.pc = vecs[n].e_pc;
      x.flush = vecs[n].e_flush; x.drop = vecs[n].e_drop; x.src = vecs[n].e_src;
      sb.push_back(x);
    end
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Owns the fetch PC and decides what IF1 requests each cycle.
Sources of the next PC, in priority order:
- commit/exception redirects
- backend branch-mispredict redirects
- IF3 predecode redirects
- sequential fetch
Latches a redirect that arrives while the ICache is busy with an uncancellable miss, and drops the stale response when that miss returns. Sits between the backend/IF3 redirect sources and IF1/ICache; drives the frontend flush.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
FETCH_BYTES, 8, bytes per aligned two-instruction fetch group

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
excRedirect  in  1  commit/exception redirect request
excPC  in  32  exception/commit target
bruRedirect  in  1  backend mispredict redirect request
bruPC  in  32  mispredict target
if3Redirect  in  1  IF3 predecode redirect request
if3PC  in  32  IF3 target
pauseReq  in  1  backend/ctrl pause; hold fetch
icacheReady  in  1  ICache accepts a new request this cycle (low = miss in flight)
icacheRespValid  in  1  ICache returns a fetch group
fetchReq  out  1  request to IF1/ICache
fetchPC  out  32  address of requested group
flushFrontend  out  1  flush IF1-IF3 regs (combinational)
dropResp  out  1  discard current ICache response (stale)
redirSrc  out  2  accepted source: 0 none, 1 if3, 2 bru, 3 exc

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- State machine: BOOT, RUN, WAIT.
  - Reset: state=BOOT, pcReg=RESET_PC, pending cleared.
  - Outputs during reset and in BOOT: fetchReq=0, flushFrontend=0, dropResp=0, redirSrc=0.
  - BOOT→RUN after exactly one cycle.
- Redirect selection (combinational):
  - sel = exc > bru > if3.
  - if3Redirect is ignored if exc or bru is asserted in the same cycle, and always ignored in WAIT.
- RUN state:
  - fetchReq = !pauseReq; fetchPC = pcReg.
  - If sel valid and icacheReady: flushFrontend=1 and redirSrc=sel this cycle; pcReg←target. Target appears on fetchPC the next cycle (1-cycle latency). The current request is squashed: fetchReq=0 that cycle.
  - If sel valid and !icacheReady: flushFrontend=1; latch {pendSrc, pendPC}; state←WAIT.
  - Else if fetchReq && icacheReady: pcReg←pcReg + (pcReg[2] ? 4 : FETCH_BYTES), i.e. realign to the 8-byte boundary.
  - pauseReq holds pcReg. Pause does not block redirects.
- WAIT state:
  - fetchReq=0.
  - dropResp = icacheRespValid; the stale line is discarded.
  - A new exc replaces any pending entry. A new bru replaces a pending bru or if3 entry. Each replacement re-asserts flushFrontend that cycle.
  - When icacheReady=1: pcReg←pendPC; state←RUN; first new request is issued the next cycle.
- Simultaneity:
  - Redirect and sequential advance in the same cycle: the redirect wins.
  - icacheRespValid in RUN with flushFrontend=1 in the same cycle → dropResp=1.
- Reset mid-WAIT: the pending redirect is lost and the machine returns to BOOT with RESET_PC.
- Arithmetic: 32-bit PC; increment wraps modulo 2^32 with no flag. Targets are not checked for alignment; a target with pc[2]=1 fetches a single-inst group.
- redirSrc shows the source latched or accepted in the current cycle, and 0 otherwise.

Decomposition:
- Shared package (ifu defs), holds:
  - redirect_src_t enum {NONE, IF3, BRU, EXC}
  - fetch_state_t {BOOT, RUN, WAIT}
  - RESET_PC and FETCH_BYTES constants
  - struct redirect_t {valid, src, pc}
- One natural sub-module: redirect_prio_sel, a pure priority mux producing redirect_t from the three sources plus the state.

Test Plan:
1. Reset 3 cycles, then release, icacheReady=1 → BOOT for 1 cycle. fetchPC then reads BFC00000, BFC00008, BFC00010 on consecutive cycles with fetchReq=1.
2. RUN at pcReg=BFC00010: bruRedirect=1 with bruPC=80001004 and if3Redirect=1 with if3PC=BFC00100 in the same cycle → flushFrontend=1, redirSrc=2. Next cycle fetchPC=80001004, then 80001008.
3. icacheReady=0 and if3Redirect to 00400020 → WAIT. Next cycle excRedirect to BFC00380 → flush re-asserted, pending overwritten. icacheRespValid arrives → dropResp=1. icacheReady=1 → next request fetchPC=BFC00380.
4. In WAIT with pending bru, assert if3Redirect → ignored: no flush, pendPC unchanged.
5. pauseReq=1 for 4 cycles at pc 00400008 → fetchReq=0 and fetchPC stable. excRedirect during the pause → pcReg updated anyway. Release → fetch resumes at the exception target.
6. Assert rst while in WAIT → next cycle BOOT; fetchPC=BFC00000; dropResp=0 and flushFrontend=0.
